// File: rtl/qspi_flash_ctrl_pkg.sv
// rtl/qspi_flash_ctrl_pkg.sv - shared bus types, FSM states, defaults and byte-request helper
package qspi_flash_ctrl_pkg;

  localparam logic [7:0]  default_read_cmd    = 8'hEB;
  localparam int unsigned default_dummy_bytes = 2;

  typedef struct packed {
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
  } mem_in_type;

  typedef struct packed {
    logic [31:0] mem_rdata;
    logic        mem_ready;
  } mem_out_type;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, RESP} flash_state_t;

  // Single engine transfer on data register 0: a write carries one byte, a read carries none.
  function automatic mem_in_type byte_req(input logic write, input logic [7:0] value);
    mem_in_type req;
    req = '0;
    req.mem_valid = 1'b1;
    if (write) begin
      req.mem_wstrb = 4'b0001;
      req.mem_wdata = {24'h0, value};
    end
    return req;
  endfunction

endpackage

// File: rtl/qspi_flash_buffer.sv
// rtl/qspi_flash_buffer.sv - one-entry word buffer, compiled only with QSPI_FLASH_BUFFER_EN
`ifdef QSPI_FLASH_BUFFER_EN
module qspi_flash_buffer (
  input  logic        clock,
  input  logic        reset,
  input  logic        fill,
  input  logic [21:0] fill_tag,
  input  logic [31:0] fill_data,
  input  logic [21:0] lookup_tag,
  output logic        hit,
  output logic [31:0] hit_data
);

  logic        valid;
  logic [21:0] tag;
  logic [31:0] data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end
  end

  assign hit      = valid && (tag == lookup_tag);
  assign hit_data = data;

endmodule
`endif

// File: rtl/qspi_flash_ctrl.sv
// rtl/qspi_flash_ctrl.sv - QSPI flash word fetch controller; optional QSPI_FLASH_BUFFER_EN word buffer
module qspi_flash_ctrl
  import qspi_flash_ctrl_pkg::*;
#(
  parameter logic [7:0]  read_cmd    = default_read_cmd,
  parameter int unsigned dummy_bytes = default_dummy_bytes
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  flash_in,
  output mem_out_type flash_out,
  output mem_in_type  qspi_in,
  input  mem_out_type qspi_out
);

  localparam logic [2:0] last_dummy = 3'(dummy_bytes - 1);

  flash_state_t state, state_n;
  logic [2:0]   cnt, cnt_n;
  logic [23:0]  addr, addr_n;
  logic [23:0]  acc, acc_n;
  logic         pend, pend_n;
  logic         done;
  logic         last_data;
  mem_in_type   qspi_n;
  logic         ready_n;
  logic [31:0]  rdata_n;

  logic unused_bits;
  assign unused_bits = ^{flash_in.mem_wdata, flash_in.mem_addr[31:24], flash_in.mem_addr[1:0],
                         qspi_out.mem_rdata[31:8]};

  // A ready pulse only counts while a byte is outstanding.
  assign done      = pend && qspi_out.mem_ready;
  assign last_data = (state == DATA) && done && (cnt == 3'd3);

`ifdef QSPI_FLASH_BUFFER_EN
  logic        buf_hit;
  logic [31:0] buf_data;

  qspi_flash_buffer u_buffer (
    .clock      (clock),
    .reset      (reset),
    .fill       (last_data),
    .fill_tag   (addr[23:2]),
    .fill_data  ({qspi_out.mem_rdata[7:0], acc}),
    .lookup_tag (flash_in.mem_addr[23:2]),
    .hit        (buf_hit),
    .hit_data   (buf_data)
  );
`endif

  function automatic logic [7:0] addr_byte(input logic [23:0] a, input logic [2:0] idx);
    case (idx)
      3'd0:    return a[23:16];
      3'd1:    return a[15:8];
      default: return a[7:0];
    endcase
  endfunction

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr;
    acc_n   = acc;
    qspi_n  = '0;
    ready_n = 1'b0;
    rdata_n = flash_out.mem_rdata;
    case (state)
      IDLE: begin
        if (flash_in.mem_valid) begin
          if (|flash_in.mem_wstrb) begin
            state_n = RESP;
            ready_n = 1'b1;
          end
`ifdef QSPI_FLASH_BUFFER_EN
          else if (buf_hit) begin
            state_n = RESP;
            ready_n = 1'b1;
            rdata_n = buf_data;
          end
`endif
          else begin
            addr_n  = {flash_in.mem_addr[23:2], 2'b00};
            cnt_n   = 3'd0;
            state_n = CMD;
            qspi_n  = byte_req(1'b1, read_cmd);
          end
        end
      end
      CMD: begin
        if (done) begin
          state_n = ADDR;
          cnt_n   = 3'd0;
          qspi_n  = byte_req(1'b1, addr_byte(addr, 3'd0));
        end
      end
      ADDR: begin
        if (done) begin
          if (cnt == 3'd2) begin
            state_n = (dummy_bytes == 0) ? DATA : DUMMY;
            cnt_n   = 3'd0;
            qspi_n  = byte_req(1'b0, 8'h00);
          end else begin
            cnt_n  = cnt + 3'd1;
            qspi_n = byte_req(1'b1, addr_byte(addr, cnt + 3'd1));
          end
        end
      end
      DUMMY: begin
        if (done) begin
          if (cnt == last_dummy) begin
            state_n = DATA;
            cnt_n   = 3'd0;
          end else begin
            cnt_n = cnt + 3'd1;
          end
          qspi_n = byte_req(1'b0, 8'h00);
        end
      end
      DATA: begin
        if (done) begin
          if (cnt == 3'd3) begin
            state_n = RESP;
            ready_n = 1'b1;
            rdata_n = {qspi_out.mem_rdata[7:0], acc};
          end else begin
            case (cnt[1:0])
              2'd0:    acc_n[7:0]   = qspi_out.mem_rdata[7:0];
              2'd1:    acc_n[15:8]  = qspi_out.mem_rdata[7:0];
              default: acc_n[23:16] = qspi_out.mem_rdata[7:0];
            endcase
            cnt_n  = cnt + 3'd1;
            qspi_n = byte_req(1'b0, 8'h00);
          end
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    pend_n = qspi_n.mem_valid || (pend && !qspi_out.mem_ready);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      addr      <= '0;
      acc       <= '0;
      pend      <= 1'b0;
      qspi_in   <= '0;
      flash_out <= '0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      addr                <= addr_n;
      acc                 <= acc_n;
      pend                <= pend_n;
      qspi_in             <= qspi_n;
      flash_out.mem_ready <= ready_n;
      flash_out.mem_rdata <= rdata_n;
    end
  end

endmodule

// File: tb/tb_qspi_flash_ctrl.sv
// tb/tb_qspi_flash_ctrl.sv - scoreboard bench for qspi_flash_ctrl with a behavioural byte engine
module tb_qspi_flash_ctrl;
  import qspi_flash_ctrl_pkg::*;

  localparam int dummies = 2;

  logic        clock;
  logic        reset;
  mem_in_type  flash_in;
  mem_out_type flash_out;
  mem_in_type  qspi_in;
  mem_out_type qspi_out;

  int n_tests = 0;
  int n_fail  = 0;
  int rsp_cnt = 0;

  logic [31:0] exp_q[$];
  logic [35:0] exp_xfer[$];
  logic [7:0]  rd_q[$];

  logic [31:0] last_rdata = 32'h0;
  logic        buf_valid  = 1'b0;
  logic [21:0] buf_tag    = '0;
  logic [31:0] buf_data   = '0;

  qspi_flash_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .flash_in  (flash_in),
    .flash_out (flash_out),
    .qspi_in   (qspi_in),
    .qspi_out  (qspi_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Engine model: answers each transfer with a ready pulse one cycle later.
  initial begin
    logic [35:0] exp;
    logic [7:0]  rbyte;
    qspi_out = '0;
    forever begin
      @(negedge clock);
      qspi_out.mem_ready = 1'b0;
      if (reset && qspi_in.mem_valid) begin
        if (exp_xfer.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL engine_unexpected: got transfer %h, expected none",
                   {qspi_in.mem_wstrb, qspi_in.mem_wdata});
        end else begin
          exp = exp_xfer.pop_front();
          check("engine_xfer", {28'h0, qspi_in.mem_wstrb, qspi_in.mem_wdata}, {28'h0, exp});
          check("engine_addr", {32'h0, qspi_in.mem_addr}, 64'h0);
        end
        rbyte = 8'hFF;
        if (qspi_in.mem_wstrb == 4'b0000 && rd_q.size() > 0) rbyte = rd_q.pop_front();
        @(negedge clock);
        qspi_out.mem_ready = 1'b1;
        qspi_out.mem_rdata = {24'hC0FFEE, rbyte};
      end
    end
  end

  // Response monitor: every ready pulse must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && flash_out.mem_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rdata %h, expected no response", flash_out.mem_rdata);
        end else begin
          check("rsp_rdata", {32'h0, flash_out.mem_rdata}, {32'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic push_miss(input logic [31:0] a, input logic [31:0] word);
    logic [23:0] wa;
    wa = {a[23:2], 2'b00};
    exp_xfer.push_back({4'b0001, 24'h0, 8'hEB});
    exp_xfer.push_back({4'b0001, 24'h0, wa[23:16]});
    exp_xfer.push_back({4'b0001, 24'h0, wa[15:8]});
    exp_xfer.push_back({4'b0001, 24'h0, wa[7:0]});
    for (int i = 0; i < dummies + 4; i++) exp_xfer.push_back(36'h0);
    for (int i = 0; i < dummies; i++) rd_q.push_back(8'hAA);
    rd_q.push_back(word[7:0]);
    rd_q.push_back(word[15:8]);
    rd_q.push_back(word[23:16]);
    rd_q.push_back(word[31:24]);
  endtask

  task automatic wait_rsp(input int start, input int poke);
    for (int i = 0; i < 200 && rsp_cnt == start; i++) begin
      if (poke > 0 && i == poke) begin
        flash_in.mem_valid = 1'b1;
        flash_in.mem_addr  = 32'h0000_0200;
      end else begin
        flash_in.mem_valid = 1'b0;
      end
      @(negedge clock);
    end
    flash_in.mem_valid = 1'b0;
    check("rsp_in_time", {63'h0, rsp_cnt != start}, 64'h1);
    repeat (poke > 0 ? 30 : 4) @(negedge clock);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] word, input int poke);
    logic hit;
    int   start;
`ifdef QSPI_FLASH_BUFFER_EN
    hit = buf_valid && (buf_tag == a[23:2]);
`else
    hit = 1'b0;
`endif
    if (hit) begin
      exp_q.push_back(buf_data);
      last_rdata = buf_data;
    end else begin
      push_miss(a, word);
      exp_q.push_back(word);
      last_rdata = word;
      buf_valid  = 1'b1;
      buf_tag    = a[23:2];
      buf_data   = word;
    end
    start    = rsp_cnt;
    flash_in = '{mem_valid: 1'b1, mem_addr: a, mem_wstrb: 4'b0000, mem_wdata: 32'h0};
    @(negedge clock);
    if (hit) check("hit_ready_t1", {63'h0, flash_out.mem_ready}, 64'h1);
    else     check("issue_t1", {63'h0, qspi_in.mem_valid}, 64'h1);
    wait_rsp(start, poke);
  endtask

  task automatic do_write(input logic [31:0] a);
    int start;
    exp_q.push_back(last_rdata);
    start    = rsp_cnt;
    flash_in = '{mem_valid: 1'b1, mem_addr: a, mem_wstrb: 4'b1111, mem_wdata: 32'h1234_5678};
    @(negedge clock);
    check("write_ready_t1", {63'h0, flash_out.mem_ready}, 64'h1);
    check("write_no_engine", {63'h0, qspi_in.mem_valid}, 64'h0);
    wait_rsp(start, 0);
  endtask

  initial begin
    reset    = 1'b0;
    flash_in = '0;
    repeat (2) @(negedge clock);
    check("reset_flash_out", {31'h0, flash_out}, 64'h0);
    check("reset_qspi_valid", {63'h0, qspi_in.mem_valid}, 64'h0);
    check("reset_qspi_bus", {28'h0, qspi_in.mem_wstrb, qspi_in.mem_wdata}, 64'h0);
    check("reset_qspi_addr", {32'h0, qspi_in.mem_addr}, 64'h0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    do_read(32'h0000_0104, 32'h4433_2211, 0);
    do_read(32'h0000_0107, 32'h3CC3_5AA5, 0);
    do_write(32'h0000_0104);
    do_read(32'h0001_2340, 32'h0403_0201, 16);

    // Abort a read while the address bytes are going out.
    push_miss(32'h0000_0240, 32'h5566_7788);
    flash_in = '{mem_valid: 1'b1, mem_addr: 32'h0000_0240, mem_wstrb: 4'b0000, mem_wdata: 32'h0};
    @(negedge clock);
    flash_in.mem_valid = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("async_reset_flash_out", {31'h0, flash_out}, 64'h0);
    check("async_reset_qspi_in", {qspi_in.mem_valid, qspi_in.mem_wstrb, qspi_in.mem_wdata},
          64'h0);
    exp_xfer.delete();
    rd_q.delete();
    buf_valid  = 1'b0;
    last_rdata = 32'h0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    do_read(32'h0000_ABCC, 32'hEFBE_ADDE, 0);
    do_read(32'h0000_0104, 32'h4433_2211, 0);
    do_read(32'h0000_0104, 32'h8877_6655, 0);
    do_read(32'h0000_0108, 32'h4030_2010, 0);

    repeat (10) @(negedge clock);
    check("rsp_drained", {32'h0, 32'(exp_q.size())}, 64'h0);
    check("xfer_drained", {32'h0, 32'(exp_xfer.size())}, 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
